// File: rtl/writeback_merge.sv
// Register-file writeback stage: merges the in-order result with late results
// queued through a round-robin arbiter and a small FIFO, with a starvation stall request.
module writeback_merge #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned NUM_LATE     = 2,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [1:0]                     data_sel_i,
    input  logic [XLEN-1:0]                pc2_i,
    input  logic [XLEN-1:0]                pc4_i,
    input  logic                           is_comp_i,
    input  logic [XLEN-1:0]                alu_result_i,
    input  logic [XLEN-1:0]                read_data_i,
    input  logic [4:0]                     rd_addr_i,
    input  logic                           rf_rw_en_i,
    input  logic                           stall_i,
    input  logic [NUM_LATE-1:0]            late_valid_i,
    input  logic [NUM_LATE*5-1:0]          late_rd_i,
    input  logic [NUM_LATE*XLEN-1:0]       late_data_i,
    output logic [NUM_LATE-1:0]            late_ready_o,
    output logic                           rf_we_o,
    output logic [4:0]                     rf_waddr_o,
    output logic [XLEN-1:0]                rf_wdata_o,
    output logic [31:0]                    pending_rd_o,
    output logic                           wb_stall_req_o,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_count_o
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned RR_W  = (NUM_LATE > 1) ? $clog2(NUM_LATE) : 1;
    localparam int unsigned ST_W  = $clog2(STARVE_LIMIT + 1);

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } entry_t;

    entry_t             mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic [RR_W-1:0]    rr_q;
    logic [ST_W-1:0]    starve_q;

    logic               io_fire;
    logic [XLEN-1:0]    io_data;
    logic               fifo_empty, fifo_full;
    logic               pop, push;
    logic               grant_any;
    logic [RR_W-1:0]    grant_idx;
    logic [NUM_LATE-1:0] grant;
    entry_t             grant_entry;
    entry_t             head;
    logic [RR_W-1:0]    rr_next;

    assign io_fire    = rf_rw_en_i & ~stall_i & (rd_addr_i != 5'd0);
    assign io_data    = data_sel_i[1] ? (is_comp_i ? pc2_i : pc4_i)
                                      : (data_sel_i[0] ? read_data_i : alu_result_i);
    assign fifo_empty = (count_q == CNT_W'(0));
    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign head       = mem_q[rd_ptr_q];
    assign pop        = ~io_fire & ~fifo_empty;

    // Round-robin search starting at rr_q; no grant while the FIFO is full
    always_comb begin : arb
        int unsigned idx;
        idx       = 0;
        grant_any = 1'b0;
        grant_idx = '0;
        for (int unsigned k = 0; k < NUM_LATE; k++) begin
            idx = 32'(rr_q) + k;
            if (idx >= NUM_LATE) idx = idx - NUM_LATE;
            if (!grant_any && late_valid_i[idx]) begin
                grant_any = 1'b1;
                grant_idx = RR_W'(idx);
            end
        end
        if (fifo_full) grant_any = 1'b0;
        grant            = '0;
        grant[grant_idx] = grant_any;
        grant_entry.rd   = late_rd_i[5*grant_idx +: 5];
        grant_entry.data = late_data_i[XLEN*grant_idx +: XLEN];
    end

    assign rr_next = (grant_idx == RR_W'(NUM_LATE - 1)) ? '0 : grant_idx + RR_W'(1);
    assign push    = grant_any & (grant_entry.rd != 5'd0);

    assign late_ready_o = {NUM_LATE{rst_ni}} & grant;
    assign rf_we_o      = rst_ni & (io_fire | ~fifo_empty);
    assign rf_waddr_o   = io_fire ? rd_addr_i : head.rd;
    assign rf_wdata_o   = io_fire ? io_data : head.data;

    // Only entries between rd_ptr and rd_ptr+count are live
    always_comb begin : pend
        logic [PTR_W-1:0] offset;
        offset       = '0;
        pending_rd_o = '0;
        for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            offset = PTR_W'(i) - rd_ptr_q;
            if ({1'b0, offset} < count_q) pending_rd_o[mem_q[i].rd] = 1'b1;
        end
    end

    assign wb_stall_req_o = (starve_q == ST_W'(STARVE_LIMIT));
    assign fifo_count_o   = count_q;

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= grant_entry;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rr_q     <= '0;
            starve_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
            if (grant_any) rr_q <= rr_next;
            if (fifo_empty || pop)
                starve_q <= '0;
            else if (starve_q != ST_W'(STARVE_LIMIT))
                starve_q <= starve_q + ST_W'(1);
        end
    end

endmodule

// File: tb/tb_writeback_merge.sv
// Scoreboard bench for writeback_merge: late results are queued on expected
// acceptance and popped when the write port is expected to drain them.
module tb_writeback_merge;

    localparam int XLEN  = 32;
    localparam int NL    = 2;
    localparam int DEPTH = 4;
    localparam int LIM   = 4;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b1;
    logic [1:0]        data_sel_i;
    logic [XLEN-1:0]   pc2_i, pc4_i, alu_result_i, read_data_i;
    logic              is_comp_i;
    logic [4:0]        rd_addr_i;
    logic              rf_rw_en_i, stall_i;
    logic [NL-1:0]     late_valid_i;
    logic [NL*5-1:0]   late_rd_i;
    logic [NL*XLEN-1:0] late_data_i;
    logic [NL-1:0]     late_ready_o;
    logic              rf_we_o;
    logic [4:0]        rf_waddr_o;
    logic [XLEN-1:0]   rf_wdata_o;
    logic [31:0]       pending_rd_o;
    logic              wb_stall_req_o;
    logic [$clog2(DEPTH):0] fifo_count_o;

    writeback_merge #(.XLEN(XLEN), .NUM_LATE(NL), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIM)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .data_sel_i(data_sel_i), .pc2_i(pc2_i), .pc4_i(pc4_i),
        .is_comp_i(is_comp_i), .alu_result_i(alu_result_i), .read_data_i(read_data_i),
        .rd_addr_i(rd_addr_i), .rf_rw_en_i(rf_rw_en_i), .stall_i(stall_i),
        .late_valid_i(late_valid_i), .late_rd_i(late_rd_i), .late_data_i(late_data_i),
        .late_ready_o(late_ready_o), .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o),
        .rf_wdata_o(rf_wdata_o), .pending_rd_o(pending_rd_o), .wb_stall_req_o(wb_stall_req_o),
        .fifo_count_o(fifo_count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t late_q[$];
    int   m_rr, m_starve;
    int   checks, failures;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Evaluate one cycle against the model, then advance to the next negedge
    task automatic tick();
        logic        io_fire;
        logic [31:0] io_data;
        logic [31:0] pend;
        logic [NL-1:0] gnt;
        int          gi;
        logic        pop;
        ent_t        e;
        #1;
        if (!rst_ni) begin
            check("rst_we", rf_we_o, 0);
            check("rst_ready", late_ready_o, 0);
            check("rst_pending", pending_rd_o, 0);
            check("rst_stall", wb_stall_req_o, 0);
            check("rst_count", fifo_count_o, 0);
            late_q.delete();
            m_rr = 0;
            m_starve = 0;
        end else begin
            io_fire = rf_rw_en_i && !stall_i && (rd_addr_i != 0);
            io_data = data_sel_i[1] ? (is_comp_i ? pc2_i : pc4_i)
                                    : (data_sel_i[0] ? read_data_i : alu_result_i);
            pend = 0;
            foreach (late_q[i]) pend[late_q[i].rd] = 1'b1;
            check("pending", pending_rd_o, pend);
            check("count", fifo_count_o, late_q.size());
            check("stall_req", wb_stall_req_o, m_starve == LIM);
            check("we", rf_we_o, io_fire || late_q.size() > 0);
            pop = 0;
            if (io_fire) begin
                check("io_waddr", rf_waddr_o, rd_addr_i);
                check("io_wdata", rf_wdata_o, io_data);
            end else if (late_q.size() > 0) begin
                check("late_waddr", rf_waddr_o, late_q[0].rd);
                check("late_wdata", rf_wdata_o, late_q[0].data);
                pop = 1;
            end
            gnt = 0;
            gi = -1;
            if (late_q.size() < DEPTH)
                for (int k = 0; k < NL; k++) begin
                    int idx;
                    idx = (m_rr + k) % NL;
                    if (gi < 0 && late_valid_i[idx]) gi = idx;
                end
            if (gi >= 0) gnt[gi] = 1'b1;
            check("ready", late_ready_o, gnt);
            if (late_q.size() == 0 || pop) m_starve = 0;
            else if (m_starve < LIM) m_starve++;
            if (pop) void'(late_q.pop_front());
            if (gi >= 0) begin
                m_rr = (gi + 1) % NL;
                e.rd = late_rd_i[5*gi +: 5];
                e.data = late_data_i[XLEN*gi +: XLEN];
                if (e.rd != 0) late_q.push_back(e);
            end
        end
        @(negedge clk_i);
    endtask

    task automatic set_late(input logic [NL-1:0] v, input logic [4:0] rd0, input logic [4:0] rd1);
        late_valid_i = v;
        late_rd_i    = {rd1, rd0};
        late_data_i  = {$urandom(), $urandom()};
    endtask

    initial begin
        int n;
        checks = 0; failures = 0; m_rr = 0; m_starve = 0;
        data_sel_i = 2'b00; pc2_i = '0; pc4_i = '0; is_comp_i = 1'b0;
        alu_result_i = '0; read_data_i = '0; rd_addr_i = '0;
        rf_rw_en_i = 1'b0; stall_i = 1'b0;
        late_valid_i = '0; late_rd_i = '0; late_data_i = '0;
        #2 rst_ni = 1'b0;
        @(negedge clk_i);
        tick();
        tick();
        rst_ni = 1'b1;

        // In-order source selection
        rf_rw_en_i = 1'b1; rd_addr_i = 5'd5; data_sel_i = 2'b00; alu_result_i = 32'h1234;
        #1;
        check("first_we", rf_we_o, 1);
        check("first_waddr", rf_waddr_o, 5);
        check("first_wdata", rf_wdata_o, 32'h1234);
        tick();
        data_sel_i = 2'b10; is_comp_i = 1'b1; pc2_i = 32'h102; pc4_i = 32'h104;
        #1;
        check("link_pc2", rf_wdata_o, 32'h102);
        tick();
        is_comp_i = 1'b0; tick();
        data_sel_i = 2'b01; read_data_i = 32'hCAFE_F00D; tick();

        // Both channels contending while the port is idle
        rf_rw_en_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            set_late(2'b11, 5'(7 + c), 5'(24 + c));
            tick();
        end
        set_late(2'b00, 5'd0, 5'd0);
        tick();
        tick();

        // Fill the FIFO behind continuous in-order writes
        rf_rw_en_i = 1'b1; rd_addr_i = 5'd3; data_sel_i = 2'b00;
        for (int c = 0; c < 4; c++) begin
            alu_result_i = $urandom();
            set_late(2'b11, 5'(10 + 2*c), 5'(11 + 2*c));
            tick();
        end
        #1;
        check("full_count", fifo_count_o, 4);
        check("full_ready", late_ready_o, 0);
        check("full_pending", pending_rd_o, (32'd1 << 10) | (32'd1 << 13) | (32'd1 << 14) | (32'd1 << 17));
        set_late(2'b00, 5'd0, 5'd0);
        n = 0;
        while (wb_stall_req_o !== 1'b1 && n < 10) begin
            alu_result_i = $urandom();
            tick();
            n++;
        end
        check("stall_req_seen", n < 10, 1);
        tick();
        stall_i = 1'b1;
        tick();
        stall_i = 1'b0;
        #1;
        check("stall_dropped", wb_stall_req_o, 0);
        check("count_after_stall", fifo_count_o, 3);
        tick();
        rf_rw_en_i = 1'b0;
        for (int c = 0; c < 4; c++) tick();

        // Late rd=0 dropped; in-order rd=0 leaves the port to the FIFO
        set_late(2'b01, 5'd0, 5'd0);
        #1;
        check("rd0_ready", late_ready_o, 2'b01);
        tick();
        rf_rw_en_i = 1'b1; rd_addr_i = 5'd4;
        set_late(2'b10, 5'd0, 5'd20);
        tick();
        set_late(2'b00, 5'd0, 5'd0);
        rd_addr_i = 5'd0;
        #1;
        check("rd0_drain_addr", rf_waddr_o, 20);
        tick();

        // Reset with entries queued
        rd_addr_i = 5'd6;
        for (int c = 0; c < 3; c++) begin
            set_late(2'b11, 5'(21 + 2*c), 5'(22 + 2*c));
            tick();
        end
        set_late(2'b00, 5'd0, 5'd0);
        #1;
        check("pre_reset_count", fifo_count_o, 3);
        rst_ni = 1'b0;
        #1;
        check("async_rst_we", rf_we_o, 0);
        check("async_rst_count", fifo_count_o, 0);
        tick();
        rst_ni = 1'b1;
        rf_rw_en_i = 1'b0;
        for (int c = 0; c < 3; c++) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule

// File: doc/writeback_merge.md
# writeback_merge

Multi-source writeback stage for the TCORE integer pipeline. It merges the in-order writeback result (ALU, load, or link PC) with results from up to NUM_LATE long-latency units (divider, late load path, and similar) onto the single register-file write port. Late results pass through a round-robin arbiter into a small FIFO. The FIFO drains whenever the in-order path leaves the port free. A starvation counter requests a one-cycle pipeline stall when the FIFO head has waited too long.

## Interface
Parameters:
- XLEN, 32, datapath width
- NUM_LATE, 2, number of late-result channels (≥1)
- FIFO_DEPTH, 4, late-result FIFO entries (power of two, ≥2)
- STARVE_LIMIT, 4, cycles the FIFO head may wait before a stall request (≥1)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; one clock, asynchronous, active-low
- data_sel_i  in  2  in-order source select: 1x = link PC, 01 = read data, 00 = ALU result
- pc2_i  in  XLEN  PC+2 (compressed link value)
- pc4_i  in  XLEN  PC+4 (link value)
- is_comp_i  in  1  instruction is compressed; selects pc2_i for link
- alu_result_i  in  XLEN  ALU result
- read_data_i  in  XLEN  load data
- rd_addr_i  in  5  in-order destination register
- rf_rw_en_i  in  1  in-order write request
- stall_i  in  1  writeback stalled; suppresses the in-order write
- late_valid_i  in  NUM_LATE  late result valid, one bit per channel
- late_rd_i  in  NUM_LATE*5  late destination registers, channel i at [5i+4:5i]
- late_data_i  in  NUM_LATE*XLEN  late data, channel i at [XLEN*i+XLEN-1:XLEN*i]
- late_ready_o  out  NUM_LATE  late result accepted this cycle
- rf_we_o  out  1  register-file write enable
- rf_waddr_o  out  5  register-file write address
- rf_wdata_o  out  XLEN  register-file write data
- pending_rd_o  out  32  bit r set while any FIFO entry targets register r
- wb_stall_req_o  out  1  request to the hazard unit to stall writeback one cycle
- fifo_count_o  out  clog2(FIFO_DEPTH)+1  occupied FIFO entries

## Operation
- In-order fire (io_fire): rf_rw_en_i & !stall_i & (rd_addr_i != 0).
- In-order data: data_sel_i[1] ? (is_comp_i ? pc2_i : pc4_i) : (data_sel_i[0] ? read_data_i : alu_result_i).
- Write port priority:
  - io_fire drives rf_we_o/rf_waddr_o/rf_wdata_o with the in-order data.
  - Otherwise, if the FIFO is non-empty, the head is written and popped.
  - Otherwise rf_we_o = 0.
  - All three port outputs are combinational.
- In-order request with rd_addr_i = 0: no write. The port counts as free, so the FIFO may drain that cycle.
- Arbitration:
  - Round-robin over late_valid_i, starting at pointer rr_q.
  - Exactly one grant per cycle, and only if count < FIFO_DEPTH.
  - late_ready_o = grant; it never depends on a same-cycle pop (no pass-through when full).
  - On accept, rr_q moves to (granted index + 1) mod NUM_LATE. Otherwise rr_q holds.
- An accepted late result with rd = 0 is dropped and not enqueued.
- A late result is never written in its accept cycle; minimum latency is 1 cycle.
- pending_rd_o is the OR of one-hot(rd) over all valid FIFO entries. It is combinational from FIFO state.
- Starvation:
  - starve_q increments, saturating at STARVE_LIMIT, each cycle the FIFO is non-empty and no pop occurs.
  - It clears on any pop or when the FIFO is empty.
  - wb_stall_req_o = (starve_q == STARVE_LIMIT).
- Push and pop in the same cycle: count unchanged; pointers both advance.
- Ordering: no WAW checking. Issue logic must use pending_rd_o to avoid an in-order write to a register with a pending late result.

## Timing
- Reset (rst_ni low, asynchronous):
  - FIFO empty; rr_q = 0; starve_q = 0.
  - rf_we_o = 0 (gated by rst_ni); late_ready_o = 0.
  - pending_rd_o = 0; wb_stall_req_o = 0; fifo_count_o = 0.
- Reset mid-operation discards all FIFO contents with no writes. The first cycle after release behaves as empty.
- Accept at edge N: the entry is visible at N+1. It is written in the first cycle ≥ N+1 with no io_fire.
- Worst-case head wait under continuous io_fire: STARVE_LIMIT cycles until wb_stall_req_o. The hazard unit responds with stall_i = 1 the next cycle, which frees the port and pops the head. wb_stall_req_o then drops the cycle after the pop.
- Wrap-around: FIFO pointers wrap modulo FIFO_DEPTH; rr_q wraps modulo NUM_LATE.

## Test plan
- Reset release, rf_rw_en_i=1, rd_addr_i=5, data_sel_i=00, alu_result_i=0x1234 → same-cycle rf_we_o=1, waddr 5, wdata 0x1234. data_sel_i=10, is_comp_i=1, pc2_i=0x102 → wdata 0x102.
- Both channels valid for 4 cycles, in-order idle, FIFO_DEPTH=4 → grants alternate 0,1,0,1. Writes appear in accept order, each one cycle after its accept. fifo_count_o never exceeds 1.
- Continuous io_fire, 4 late accepts → count reaches 4; late_ready_o = 0 while count = 4. pending_rd_o shows all four rd bits. wb_stall_req_o rises 4 cycles after the first accept.
- Drive stall_i=1 one cycle after wb_stall_req_o → head written that cycle. starve_q clears, wb_stall_req_o falls, count decrements to 3.
- Late result with rd=0 → accepted (ready=1), no enqueue, no write. In-order rd=0 with FIFO non-empty → FIFO head written that cycle.
- Assert rst_ni=0 with 3 entries queued → all outputs reach reset values immediately; no write occurs after release.
